add4_accum: RTL and testbench
=============================

# add4_accum

Frame accumulator that sits directly downstream of the 4-bit half-adder adder. It accepts 4-bit operand pairs over a valid/ready handshake and forms each 5-bit sum through an internal instance of that adder. It accumulates `N_SUMS` sums per frame, then presents the frame total, sample count and overflow flag on an output valid/ready handshake. It is the first sequential stage fed by the adder datapath.

## Interface
- `N_SUMS`, default 4: number of sums per frame; must be ≥ 1.
- `ACC_W`, default 8: accumulator width; must be ≥ 5.
- `CNT_W`, default `$clog2(N_SUMS+1)`: sample-count width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `a`  in  4  operand A, unsigned.
- `b`  in  4  operand B, unsigned.
- `flush`  in  1  close the current frame early; level-sampled.
- `out_valid`  out  1  frame result held.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_W  frame total.
- `out_cnt`  out  CNT_W  number of sums in the frame.
- `out_ovf`  out  1  accumulator overflowed during the frame.

## Operation
- The FSM has three states: IDLE (count 0), ACCUM (0 < count < N_SUMS), HOLD (result presented).
- `in_ready` is 1 in IDLE and ACCUM, and 0 in HOLD.
- A pair is accepted on a cycle where `in_valid && in_ready`. On acceptance:
  - acc ← acc + zero-extended 5-bit sum;
  - count ← count + 1.
- IDLE → ACCUM on the first accept, unless `N_SUMS` = 1 or `flush` is high; in either of those cases the block goes to HOLD.
- ACCUM → HOLD when an accept brings count to `N_SUMS`, or when `flush` is high.
- `flush` in the same cycle as an accept: the accepted sum is included, then the block goes to HOLD.
- `flush` in IDLE with no accept is ignored; the block never produces an empty frame.
- In HOLD:
  - `out_sum`, `out_cnt` and `out_ovf` are stable, and `out_valid` = 1;
  - on `out_ready`, the block goes to IDLE and acc, count and ovf clear to 0;
  - `flush` is ignored.
- Arithmetic: the unbounded frame total is compared against 2^ACC_W − 1. If the total exceeds it, `out_ovf` is set and stays set for the rest of the frame; the `out_sum` value follows the Configuration section.
- Reset (asynchronous, any state): the FSM goes to IDLE, and `in_ready` = 1 once `rst_n` deasserts. At reset:
  - `out_valid` = 0, `out_sum` = 0, `out_cnt` = 0, `out_ovf` = 0;
  - any partial frame is discarded.

## Timing
- The adder path is combinational into the accumulator register: one accept per cycle, with no bubbles.
- `out_valid` rises on the edge that samples the final accept or the flush. The latency from the last accept to `out_valid` is 1 cycle.
- The result handshake completes on the edge where `out_valid && out_ready`.
- `in_ready` returns to 1 in the following cycle. There is no same-cycle pass-through from output to input, so the worst-case throughput is `N_SUMS` accepts plus 1 HOLD cycle per frame.
- Back-pressure: HOLD can last indefinitely. Upstream data is held off by `in_ready` = 0 and is not lost.

## Configuration
- `ADD4_ACCUM_SAT_EN` defined: on overflow, acc clamps to 2^ACC_W − 1 and stays clamped for the rest of the frame; `out_ovf` = 1.
- `ADD4_ACCUM_SAT_EN` undefined: acc wraps modulo 2^ACC_W; `out_ovf` = 1 (sticky per frame).

## Structure
- Package `add4_pkg` holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - `ADD4_OPERAND_W` = 4 and `ADD4_SUM_W` = 5.
- Sub-module `add4_hadd`: a 4-bit + 4-bit → 5-bit adder built from half-adder cells, purely combinational, instantiated once.
- Everything else is in `add4_accum`: the FSM, count and acc registers, and overflow detection. The overflow compare uses an `ACC_W`+1-bit intermediate.

## Test plan
- Normal frame, `N_SUMS`=4: pairs (3,3), (3,4), (5,3), (6,2) on consecutive cycles → 1 cycle after the last accept, `out_valid`=1, `out_sum`=29, `out_cnt`=4, `out_ovf`=0.
- Overflow, `N_SUMS`=16, `ACC_W`=8: 16× (15,15).
  - Without `ADD4_ACCUM_SAT_EN` → `out_sum`=224, `out_ovf`=1.
  - With it → `out_sum`=255, `out_ovf`=1.
- Back-pressure: after a complete frame, hold `out_ready`=0 for 5 cycles with `in_valid`=1 and (1,1) presented → `in_ready`=0 and outputs unchanged. On `out_ready`=1 → IDLE next cycle, and the pending pair is accepted as the first sum of the new frame.
- Flush: pairs (1,0), (0,1), then `flush` alone → `out_sum`=2, `out_cnt`=2. Also: `flush` asserted together with a third pair (2,2) → `out_sum`=6, `out_cnt`=3.
- Flush in IDLE: `flush`=1 with `in_valid`=0 for 3 cycles → `out_valid` stays 0.
- Reset mid-frame: after 2 accepts, pulse `rst_n` low asynchronously between edges → all outputs are 0 immediately. The next full frame of (1,1)×4 gives `out_sum`=8, `out_cnt`=4.

Source files
------------

// File: rtl/add4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add4_pkg
//  Purpose  : Shared types and widths for the add4 adder/accumulator slice.
//  Revision : 1.0 - initial release
// ============================================================================
package add4_pkg;

    localparam int ADD4_OPERAND_W = 4;
    localparam int ADD4_SUM_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } add4_state_e;

endpackage : add4_pkg
`default_nettype wire

// File: rtl/add4_hadd.sv
`default_nettype none
// ============================================================================
//  Module   : add4_hadd
//  Purpose  : 4-bit + 4-bit -> 5-bit unsigned ripple adder built purely from
//             half-adder cells (two half adders plus an OR per bit).
//  Revision : 1.0 - initial release
// ============================================================================
module add4_hadd
    import add4_pkg::*;
(
    input  logic [ADD4_OPERAND_W-1:0] a,
    input  logic [ADD4_OPERAND_W-1:0] b,
    output logic [ADD4_SUM_W-1:0]     sum
);

    // carry[0] is the ripple input; the top carry becomes the sum MSB
    logic [ADD4_OPERAND_W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ADD4_OPERAND_W; i++) begin : g_bit
        logic hs1_s;
        logic hs1_c;
        logic hs2_c;

        // first half adder combines the operand bits
        assign hs1_s = a[i] ^ b[i];
        assign hs1_c = a[i] & b[i];
        // second half adder folds in the incoming carry
        assign sum[i]     = hs1_s ^ carry[i];
        assign hs2_c      = hs1_s & carry[i];
        assign carry[i+1] = hs1_c | hs2_c;
    end : g_bit

    assign sum[ADD4_SUM_W-1] = carry[ADD4_OPERAND_W];

endmodule : add4_hadd
`default_nettype wire

// File: rtl/add4_accum.sv
`default_nettype none
// ============================================================================
//  Module   : add4_accum
//  Purpose  : Frame accumulator fed by the add4_hadd adder. Accepts operand
//             pairs over valid/ready, accumulates N_SUMS sums (or fewer on
//             flush) and presents total, count and overflow on valid/ready.
//  Options  : ADD4_ACCUM_SAT_EN - saturate the accumulator on overflow
//             (default: wrap modulo 2^ACC_W). out_ovf is sticky either way.
//  Revision : 1.0 - initial release
// ============================================================================
module add4_accum
    import add4_pkg::*;
#(
    parameter int N_SUMS = 4,
    parameter int ACC_W  = 8,
    parameter int CNT_W  = $clog2(N_SUMS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADD4_OPERAND_W-1:0] a,
    input  logic [ADD4_OPERAND_W-1:0] b,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_sum,
    output logic [CNT_W-1:0]          out_cnt,
    output logic                      out_ovf
);

    localparam int               ACC_WX   = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SUMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    add4_state_e          state_q, state_d;
    logic [ACC_W-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 ovf_q,   ovf_d;

    logic [ADD4_SUM_W-1:0] pair_sum;
    logic [ACC_W:0]        acc_wide;
    logic [ACC_W-1:0]      acc_next;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  accept;

    add4_hadd u_hadd (
        .a   (a),
        .b   (b),
        .sum (pair_sum)
    );

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_ONE;

    // One extra bit above the accumulator catches the carry out of this add
    assign acc_wide = {1'b0, acc_q} + ACC_WX'(pair_sum);

`ifdef ADD4_ACCUM_SAT_EN
    // Once clamped, the accumulator stays at full scale for the rest of the frame
    assign acc_next = (ovf_q || acc_wide[ACC_W]) ? ACC_MAX : acc_wide[ACC_W-1:0];
`else
    assign acc_next = acc_wide[ACC_W-1:0];
`endif

    // Next-state and datapath update for the frame FSM
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | acc_wide[ACC_W];
                    // flush with an accept keeps the sum and closes the frame
                    if ((cnt_inc == CNT_LAST) || flush) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end else if ((state_q == ACCUM) && flush) begin
                    // only a non-empty frame may be closed early
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and accumulator registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;

endmodule : add4_accum
`default_nettype wire

// File: tb/tb_add4_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add4_accum
//  Purpose  : Self-checking bench for add4_accum: directed frames plus
//             randomized traffic against a frame-level reference model, and
//             an overflow frame on a 16-sum instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add4_accum;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int CW  = $clog2(N + 1);
    localparam int N16 = 16;
    localparam int CW16 = $clog2(N16 + 1);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    a         = '0;
    logic [3:0]    b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_cnt;
    logic          out_ovf;

    logic            in_valid16  = 1'b0;
    logic            out_ready16 = 1'b0;
    logic [3:0]      a16         = '0;
    logic [3:0]      b16         = '0;
    logic            in_ready16;
    logic            out_valid16;
    logic [AW-1:0]   out_sum16;
    logic [CW16-1:0] out_cnt16;
    logic            out_ovf16;

    int n_vec = 0;
    int n_err = 0;

    // frame-level reference: running total, number of sums, result pending
    int m_total = 0;
    int m_cnt   = 0;
    bit m_hold  = 1'b0;

    always #5 clk = ~clk;

    add4_accum #(.N_SUMS(N), .ACC_W(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    add4_accum #(.N_SUMS(N16), .ACC_W(AW)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .flush     (1'b0),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_sum   (out_sum16),
        .out_cnt   (out_cnt16),
        .out_ovf   (out_ovf16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reported frame total for an unbounded total
    function automatic int exp_sum(input int total, input int aw);
        int mx;
        mx = (1 << aw) - 1;
`ifdef ADD4_ACCUM_SAT_EN
        return (total > mx) ? mx : total;
`else
        return total % (mx + 1);
`endif
    endfunction

    task automatic model_reset();
        m_total = 0;
        m_cnt   = 0;
        m_hold  = 1'b0;
    endtask

    // apply the frame rules to whatever inputs were present at this edge
    task automatic model_edge();
        if (m_hold) begin
            if (out_ready) model_reset();
        end else begin
            if (in_valid) begin
                m_total += int'(a) + int'(b);
                m_cnt++;
            end
            if ((m_cnt > 0) && (flush || (m_cnt == N))) m_hold = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":in_ready"},  32'(in_ready),  32'(!m_hold));
        check({tag, ":out_valid"}, 32'(out_valid), 32'(m_hold));
        if (m_hold) begin
            check({tag, ":out_sum"}, 32'(out_sum), 32'(exp_sum(m_total, AW)));
            check({tag, ":out_cnt"}, 32'(out_cnt), 32'(m_cnt));
            check({tag, ":out_ovf"}, 32'(out_ovf), 32'(m_total > (1 << AW) - 1));
        end
    endtask

    // drive after a falling edge, update the model at the rising edge, check at the next fall
    task automatic step(input bit v, input int av, input int bv, input bit f, input bit r,
                        input string tag);
        in_valid  = v;
        a         = av[3:0];
        b         = bv[3:0];
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_cnt",   32'(out_cnt),   32'd0);
        check("rst_ovf",   32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        // normal frame
        step(1, 3, 3, 0, 0, "norm");
        step(1, 3, 4, 0, 0, "norm");
        step(1, 5, 3, 0, 0, "norm");
        step(1, 6, 2, 0, 0, "norm");
        check("norm_valid", 32'(out_valid), 32'd1);
        check("norm_sum",   32'(out_sum),   32'd29);
        check("norm_cnt",   32'(out_cnt),   32'd4);
        check("norm_ovf",   32'(out_ovf),   32'd0);

        // back-pressure with a pending pair
        repeat (5) step(1, 1, 1, 0, 0, "bp_hold");
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_sum",      32'(out_sum),  32'd29);
        step(1, 1, 1, 0, 1, "bp_release");
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < N; i++) step(1, 1, 1, 0, 0, "bp_frame");
        check("bp_frame_sum", 32'(out_sum), 32'd8);
        check("bp_frame_cnt", 32'(out_cnt), 32'd4);
        step(0, 0, 0, 0, 1, "bp_done");

        // flush alone
        step(1, 1, 0, 0, 0, "fl1");
        step(1, 0, 1, 0, 0, "fl1");
        step(0, 0, 0, 1, 0, "fl1");
        check("fl1_sum", 32'(out_sum), 32'd2);
        check("fl1_cnt", 32'(out_cnt), 32'd2);
        step(0, 0, 0, 0, 1, "fl1_done");

        // flush together with an accept
        step(1, 1, 0, 0, 0, "fl2");
        step(1, 0, 1, 0, 0, "fl2");
        step(1, 2, 2, 1, 0, "fl2");
        check("fl2_sum", 32'(out_sum), 32'd6);
        check("fl2_cnt", 32'(out_cnt), 32'd3);
        step(0, 0, 0, 0, 1, "fl2_done");

        // flush in IDLE produces no frame
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, "fl_idle");
            check("fl_idle_valid", 32'(out_valid), 32'd0);
        end

        // asynchronous reset between edges mid-frame
        step(1, 1, 1, 0, 0, "rst_mid");
        step(1, 1, 1, 0, 0, "rst_mid");
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("amid_valid", 32'(out_valid), 32'd0);
        check("amid_sum",   32'(out_sum),   32'd0);
        check("amid_cnt",   32'(out_cnt),   32'd0);
        check("amid_ovf",   32'(out_ovf),   32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) step(1, 1, 1, 0, 0, "after_rst");
        check("after_rst_sum", 32'(out_sum), 32'd8);
        check("after_rst_cnt", 32'(out_cnt), 32'd4);
        step(0, 0, 0, 0, 1, "after_rst_done");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, "rand");
        end
        step(0, 0, 0, 0, 1, "rand_drain");

        // overflow frame on the 16-sum instance: 16 x (15,15) = 480
        in_valid16 = 1'b1;
        a16        = 4'd15;
        b16        = 4'd15;
        for (int i = 0; i < N16; i++) begin
            check("ovf_in_ready", 32'(in_ready16), 32'd1);
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        check("ovf_valid", 32'(out_valid16), 32'd1);
        check("ovf_sum",   32'(out_sum16),   32'(exp_sum(N16 * 30, AW)));
        check("ovf_cnt",   32'(out_cnt16),   32'(N16));
        check("ovf_flag",  32'(out_ovf16),   32'd1);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("ovf_release_valid", 32'(out_valid16), 32'd0);
        check("ovf_release_flag",  32'(out_ovf16),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_add4_accum
`default_nettype wire
